// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux_nto1_scan block:
//   - mux_mode_e : operating mode (manual select or automatic scan)
//   - reset constants for the single-bit registered outputs and the mode state
//   - mux_clog2  : elaboration-time ceil(log2(n)), floored at 1 bit
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    localparam logic      RST_VALID = 1'b0;
    localparam logic      RST_PULSE = 1'b0;
    localparam mux_mode_e RST_MODE  = MODE_MANUAL;

    // Select width for n channels; never narrower than one bit.
    function automatic int mux_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        for (int i = 0; i < 32; i++) begin
            if (v < n) begin
                v = v * 2;
                r = r + 1;
            end else begin
                v = v;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_next_sel.sv
// -----------------------------------------------------------------------------
// mux_next_sel
// Combinational round-robin finder. Returns the lowest enabled channel index
// strictly above the current select; if none exists it wraps to the lowest
// enabled index overall (which is the current channel itself when it is the
// only one enabled).
// Ports:
//   cur_sel_i  [SEL_W]     current channel select
//   ch_en_i    [CH_COUNT]  channel enable mask
//   next_sel_o [SEL_W]     next enabled channel (holds cur_sel_i if none)
//   any_en_o               at least one channel is enabled
// -----------------------------------------------------------------------------
module mux_next_sel
    import mux_pkg::*;
#(
    parameter  int CH_COUNT = 4,
    localparam int SEL_W    = mux_clog2(CH_COUNT)
) (
    input  logic [SEL_W-1:0]    cur_sel_i,
    input  logic [CH_COUNT-1:0] ch_en_i,
    output logic [SEL_W-1:0]    next_sel_o,
    output logic                any_en_o
);

    logic [SEL_W-1:0] above_sel_s;
    logic [SEL_W-1:0] wrap_sel_s;
    logic             above_found_s;

    // Descending walk so the lowest qualifying index is the last one written.
    always_comb begin
        above_sel_s   = cur_sel_i;
        wrap_sel_s    = cur_sel_i;
        above_found_s = 1'b0;
        for (int k = CH_COUNT - 1; k >= 0; k--) begin
            if (ch_en_i[k]) begin
                wrap_sel_s = SEL_W'(k);
                if (k > int'(cur_sel_i)) begin
                    above_sel_s   = SEL_W'(k);
                    above_found_s = 1'b1;
                end else begin
                    above_found_s = above_found_s;
                end
            end else begin
                wrap_sel_s = wrap_sel_s;
            end
        end
        next_sel_o = above_found_s ? above_sel_s : wrap_sel_s;
        any_en_o   = |ch_en_i;
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// mux_nto1_scan
// N-channel, W-bit registered multiplexer with per-channel enable mask and an
// optional automatic scan mode that steps through enabled channels, holding
// each for a programmable dwell time.
//
// Build option: define MUX_SCAN_EN to include the scan state, dwell counter and
// next-channel logic. Without it the block is manual-select only: mode and
// dwell are ignored and switch_pulse is tied low.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   ch_in         channel data, channel k at [k*DATA_W +: DATA_W]
//   ch_en         channel enable mask
//   mode          0 = manual, 1 = scan
//   sel_in        manual channel select
//   dwell         scan dwell in cycles (0 behaves as 1)
//   mux_out       registered selected data (0 when not valid)
//   sel_out       channel currently driving mux_out
//   out_valid     mux_out comes from an in-range, enabled channel
//   switch_pulse  one-cycle pulse in the cycle a new scan channel first appears
// -----------------------------------------------------------------------------
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter  int CH_COUNT = 4,
    parameter  int DATA_W   = 8,
    parameter  int DWELL_W  = 8,
    localparam int SEL_W    = mux_clog2(CH_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH_COUNT*DATA_W-1:0] ch_in,
    input  logic [CH_COUNT-1:0]        ch_en,
    input  logic                       mode,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic [DWELL_W-1:0]         dwell,
    output logic [DATA_W-1:0]          mux_out,
    output logic [SEL_W-1:0]           sel_out,
    output logic                       out_valid,
    output logic                       switch_pulse
);

    // Data of channel sel, or zero when sel is out of range.
    function automatic logic [DATA_W-1:0] pick_data(
        input logic [CH_COUNT*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]           sel
    );
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int k = 0; k < CH_COUNT; k++) begin
            if (int'(sel) == k) begin
                r = bus[k*DATA_W +: DATA_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // True when sel names an existing channel whose enable bit is set.
    function automatic logic chan_enabled(
        input logic [CH_COUNT-1:0] en,
        input logic [SEL_W-1:0]    sel
    );
        logic r;
        r = 1'b0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (int'(sel) == k) begin
                r = en[k];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;
    logic              valid_q;
    logic              valid_d;

`ifdef MUX_SCAN_EN
    logic              pulse_q;
    logic              pulse_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    mux_mode_e         state_q;
    mux_mode_e         state_d;
    logic [DWELL_W-1:0] cnt_base_s;
    logic [DWELL_W-1:0] dwell_last_s;
    logic [SEL_W-1:0]  next_sel_s;
    logic              any_en_s;

    mux_next_sel #(
        .CH_COUNT (CH_COUNT)
    ) u_next_sel (
        .cur_sel_i  (sel_q),
        .ch_en_i    (ch_en),
        .next_sel_o (next_sel_s),
        .any_en_o   (any_en_s)
    );

    // Last count value of a dwell period; a dwell of 0 behaves as 1.
    always_comb begin
        if (dwell == {DWELL_W{1'b0}}) begin
            dwell_last_s = {DWELL_W{1'b0}};
        end else begin
            dwell_last_s = dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_scan_s;
    assign unused_scan_s = ^{mode, dwell};
`endif

    // Next-state for select, valid, pulse and dwell counter; data follows select.
    always_comb begin
        sel_d   = sel_in;
        valid_d = chan_enabled(ch_en, sel_in);
`ifdef MUX_SCAN_EN
        pulse_d    = 1'b0;
        cnt_d      = {DWELL_W{1'b0}};
        state_d    = mux_mode_e'(mode);
        // Counting restarts from zero on the first scan cycle after manual.
        cnt_base_s = (state_q == MODE_SCAN) ? cnt_q : {DWELL_W{1'b0}};
        if (state_d == MODE_SCAN) begin
            if (!any_en_s) begin
                sel_d   = sel_q;
                valid_d = 1'b0;
            end else if (!chan_enabled(ch_en, sel_q) || (cnt_base_s >= dwell_last_s)) begin
                // Dwell expired, or current channel dropped out of the mask.
                sel_d   = next_sel_s;
                valid_d = 1'b1;
                pulse_d = 1'b1;
            end else begin
                sel_d   = sel_q;
                valid_d = 1'b1;
                cnt_d   = cnt_base_s + {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {DWELL_W{1'b0}};
        end
`endif
        if (valid_d) begin
            data_d = pick_data(ch_in, sel_d);
        end else begin
            data_d = {DATA_W{1'b0}};
        end
    end

    // Output registers shared by both builds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {DATA_W{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            valid_q <= RST_VALID;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_SCAN_EN
    // Scan state, dwell counter and switch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_MODE;
            cnt_q   <= {DWELL_W{1'b0}};
            pulse_q <= RST_PULSE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign switch_pulse = pulse_q;
`else
    assign switch_pulse = 1'b0;
`endif

    assign mux_out   = data_q;
    assign sel_out   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_scan
// Directed self-checking bench for mux_nto1_scan (CH_COUNT=4, DATA_W=8,
// DWELL_W=8). Scan-mode sequences are exercised when MUX_SCAN_EN is defined;
// otherwise the bench confirms mode is ignored and switch_pulse stays low.
// -----------------------------------------------------------------------------
module tb_mux_nto1_scan;

    localparam int CH_COUNT = 4;
    localparam int DATA_W   = 8;
    localparam int DWELL_W  = 8;
    localparam int SEL_W    = 2;

    logic                       clk;
    logic                       rst_n;
    logic [CH_COUNT*DATA_W-1:0] ch_in;
    logic [CH_COUNT-1:0]        ch_en;
    logic                       mode;
    logic [SEL_W-1:0]           sel_in;
    logic [DWELL_W-1:0]         dwell;
    logic [DATA_W-1:0]          mux_out;
    logic [SEL_W-1:0]           sel_out;
    logic                       out_valid;
    logic                       switch_pulse;

    int checks_cnt;
    int errors_cnt;

    logic [7:0] data_tbl [4];

    mux_nto1_scan #(
        .CH_COUNT (CH_COUNT),
        .DATA_W   (DATA_W),
        .DWELL_W  (DWELL_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_in        (ch_in),
        .ch_en        (ch_en),
        .mode         (mode),
        .sel_in       (sel_in),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .sel_out      (sel_out),
        .out_valid    (out_valid),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_data,
                              input logic [1:0] e_sel, input logic e_valid,
                              input logic e_pulse);
        check_eq({tag, ".mux_out"},      {24'h0, mux_out},      {24'h0, e_data});
        check_eq({tag, ".sel_out"},      {30'h0, sel_out},      {30'h0, e_sel});
        check_eq({tag, ".out_valid"},    {31'h0, out_valid},    {31'h0, e_valid});
        check_eq({tag, ".switch_pulse"}, {31'h0, switch_pulse}, {31'h0, e_pulse});
    endtask

`ifdef MUX_SCAN_EN
    logic [1:0] scan_sel_tbl [9];
    logic       scan_pls_tbl [9];
`endif

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        data_tbl[0] = 8'hAA;
        data_tbl[1] = 8'hBB;
        data_tbl[2] = 8'hCC;
        data_tbl[3] = 8'hDD;

        rst_n  = 1'b0;
        ch_in  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        ch_en  = 4'hF;
        mode   = 1'b0;
        sel_in = 2'd3;
        dwell  = 8'd0;
        #1;
        check_outs("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;

        // Manual select of every channel, one cycle latency.
        for (int s = 0; s < 4; s++) begin
            sel_in = 2'(s);
            step();
            check_outs($sformatf("manual_sel%0d", s), data_tbl[s], 2'(s), 1'b1, 1'b0);
        end

        // Disabled channel gives invalid and zero data.
        ch_en  = 4'b1011;
        sel_in = 2'd2;
        step();
        check_outs("manual_dis", 8'h00, 2'd2, 1'b0, 1'b0);

        // Enabled channel with live data change.
        sel_in = 2'd3;
        ch_in  = {8'h5A, 8'hCC, 8'hBB, 8'hAA};
        step();
        check_outs("manual_live", 8'h5A, 2'd3, 1'b1, 1'b0);
        ch_in  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

`ifdef MUX_SCAN_EN
        // Scan, dwell=3, mask 1101, starting from channel 0.
        scan_sel_tbl[0] = 2'd0; scan_pls_tbl[0] = 1'b0;
        scan_sel_tbl[1] = 2'd0; scan_pls_tbl[1] = 1'b0;
        scan_sel_tbl[2] = 2'd2; scan_pls_tbl[2] = 1'b1;
        scan_sel_tbl[3] = 2'd2; scan_pls_tbl[3] = 1'b0;
        scan_sel_tbl[4] = 2'd2; scan_pls_tbl[4] = 1'b0;
        scan_sel_tbl[5] = 2'd3; scan_pls_tbl[5] = 1'b1;
        scan_sel_tbl[6] = 2'd3; scan_pls_tbl[6] = 1'b0;
        scan_sel_tbl[7] = 2'd3; scan_pls_tbl[7] = 1'b0;
        scan_sel_tbl[8] = 2'd0; scan_pls_tbl[8] = 1'b1;
        ch_en  = 4'b1101;
        sel_in = 2'd0;
        step();
        check_outs("scan3_start", 8'hAA, 2'd0, 1'b1, 1'b0);
        mode  = 1'b1;
        dwell = 8'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            check_outs($sformatf("scan3_c%0d", i), data_tbl[scan_sel_tbl[i]],
                       scan_sel_tbl[i], 1'b1, scan_pls_tbl[i]);
        end

        // Dwell 0 acts as 1: advance every cycle with pulse held high.
        ch_en = 4'hF;
        dwell = 8'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_outs($sformatf("scan0_c%0d", i), data_tbl[i % 4], 2'(i % 4), 1'b1, 1'b1);
        end

        // Empty mask: hold select, invalid, no pulses.
        ch_en = 4'h0;
        step();
        check_outs("scan_none_a", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check_outs("scan_none_b", 8'h00, 2'd0, 1'b0, 1'b0);

        // Dwell 5, drop current channel at cnt=2.
        ch_en = 4'hF;
        dwell = 8'd5;
        step();
        check_outs("scan5_c1", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        check_outs("scan5_c2", 8'hAA, 2'd0, 1'b1, 1'b0);
        ch_en = 4'b1110;
        step();
        check_outs("scan5_drop", 8'hBB, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs($sformatf("scan5_hold%0d", i), 8'hBB, 2'd1, 1'b1, 1'b0);
        end
        step();
        check_outs("scan5_next", 8'hCC, 2'd2, 1'b1, 1'b1);
`else
        // Without scan support mode and dwell have no effect.
        ch_en  = 4'hF;
        mode   = 1'b1;
        dwell  = 8'd0;
        sel_in = 2'd1;
        step();
        check_outs("noscan_a", 8'hBB, 2'd1, 1'b1, 1'b0);
        step();
        check_outs("noscan_b", 8'hBB, 2'd1, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-operation, held for three cycles.
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        mode   = 1'b0;
        sel_in = 2'd2;
        ch_en  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check_outs("rst_held", 8'h00, 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        check_outs("post_rst", 8'hCC, 2'd2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
